modular_sub_half_pipe: RTL and testbench
========================================

// Module: modular_sub_half_pipe
// PURPOSE
//  Pipelined modular add/subtract unit over Z_q, q = 12289, with optional divide-by-2 scaling.
//  Serves as the inverse-NTT (Gentleman-Sande) datapath counterpart of the combinational forward adder:
//  subtraction path, plus per-stage 1/2 scaling so no final n^-1 multiply is needed.
//  Sits between the coefficient RAM read port and the butterfly multiplier; valid/ready on both sides.
// PARAMETERS
//  data_width  14     coefficient width; all operands/results in [0, M-1]
//  M           12289  modulus; must satisfy M < 2^data_width and M odd
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           synchronous reset, active low
//  in_valid   in   1           operand beat offered
//  in_ready   out  1           unit accepts beat this cycle
//  op_sub     in   1           0: x+y mod M, 1: x-y mod M
//  half_en    in   1           1: result further multiplied by 2^-1 mod M
//  x_in       in   data_width  operand x
//  y_in       in   data_width  operand y
//  out_valid  out  1           result beat valid
//  out_ready  in   1           downstream accepts result
//  z_out      out  data_width  result
//  range_err  out  1           sticky: some accepted operand was >= M
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): out_valid=0, z_out=0, range_err=0, all pipe valids 0; in_ready=1 after reset.
//  Transfer rules: input beat on in_valid&in_ready; output beat on out_valid&out_ready.
//  Pipeline: 2 register stages; fixed latency 2 cycles when not stalled.
//  Advance enable adv = ~out_valid | out_ready.
//  in_ready = adv (combinational; no comb path from in_valid to in_ready).
//  Stall: when adv=0, both stages hold contents and z_out is stable; no beat is dropped or duplicated.
//  Stage 1: add: {c,s} = x+y (data_width+1 bits).
//  Stage 1: sub: {b,s} = x-y; borrow b=1 means result wraps.
//  Stage 1 registers s, the carry/borrow flag, op_sub and half_en.
//  Stage 2: add: r = (c | s>=M) ? s-M : s.
//  Stage 2: sub: r = b ? s+M : s (mod 2^data_width).
//  Stage 2: half_en=1: h = r[0] ? (r+M)>>1 : r>>1, computed with data_width+1 bits; z_out=h, else z_out=r.
//  Result always in [0, M-1] for canonical inputs.
//  Non-canonical input (x>=M or y>=M): sets range_err on the accept cycle; z_out unspecified but deterministic.
//  range_err clears only on reset.
//  Back-to-back: full throughput, one beat per cycle while out_ready=1.
//  Bubbles propagate as valid=0 slots.
//  Reset mid-operation: all in-flight beats discarded; nothing emitted after reset deasserts until a new input beat is accepted.
//  op_sub/half_en are sampled per beat with the operands.
//  Changing op_sub/half_en between beats affects only later beats.
// TESTING
//  1 add wrap: x=12288,y=1,op_sub=0,half_en=0 -> z_out=0 exactly 2 cycles after accept.
//  1 add no wrap: x=5000,y=6000 -> 11000.
//  2 sub borrow: x=0,y=1,op_sub=1 -> 12288; x=5,y=3 -> 2; x=y=7000 -> 0.
//  3 halving: x=3,y=4,add,half -> 6148.
//  3 halving: x=5,y=3,sub,half -> 1.
//  3 halving: x=0,y=12288,sub,half -> 6145 (r=1 odd).
//  4 stall: stream 8 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while full, z_out held.
//  4 stall: order and values match golden model, no loss or duplicates.
//  5 reset mid-flight: 2 beats in pipe, rst_n=0 one cycle -> out_valid=0 next cycle, range_err=0.
//  5 reset mid-flight: first output after reset comes from the first post-reset beat.
//  6 range: x=12289 accepted -> range_err=1 and stays 1 through later valid beats until reset.
//  6 random: 10k random canonical beats with random op/half/ready -> matches (x±y)*2^-half mod 12289.

Source files
------------

// File: rtl/modular_sub_half_pipe_if.sv
// Operand/result handshake bundle for the modular add/sub pipe.
// The master drives operands and result-ready. The slave (the datapath) drives the rest.
interface modular_sub_half_pipe_if #(
    parameter int data_width = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  op_sub;
    logic                  half_en;
    logic [data_width-1:0] x_in;
    logic [data_width-1:0] y_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] z_out;
    logic                  range_err;

    modport master (
        output in_valid, op_sub, half_en, x_in, y_in, out_ready,
        input  in_ready, out_valid, z_out, range_err
    );

    modport slave (
        input  in_valid, op_sub, half_en, x_in, y_in, out_ready,
        output in_ready, out_valid, z_out, range_err
    );
endinterface

// File: rtl/modular_sub_half_pipe.sv
// Two-stage modular add/subtract over Z_M with optional multiply by 2^-1 mod M.
// Stage 1 forms the raw sum/difference. Stage 2 reduces it, optionally halves it, and registers the result.
module modular_sub_half_pipe #(
    parameter int data_width = 14,
    parameter int M          = 12289
) (
    input  logic                    clk,
    input  logic                    rst_n,
    modular_sub_half_pipe_if.slave  io
);
    localparam logic [data_width-1:0] MOD   = data_width'(M);
    localparam logic [data_width:0]   MOD_W = (data_width + 1)'(M);

    logic                  adv;
    logic                  accept;
    logic                  non_canon;

    logic [data_width:0]   sum_w;
    logic [data_width:0]   dif_w;
    logic [data_width-1:0] s_nxt;
    logic                  f_nxt;

    logic                  v1;
    logic [data_width-1:0] s1;
    logic                  f1;
    logic                  op1;
    logic                  h1;

    logic [data_width-1:0] r;
    logic [data_width:0]   r_ext;
    logic [data_width:0]   h_ext;
    logic [data_width-1:0] result;

    // The whole pipe moves as one unit, so input readiness follows output space only.
    assign adv         = ~io.out_valid | io.out_ready;
    assign io.in_ready = adv;
    assign accept      = io.in_valid & adv;
    assign non_canon   = (io.x_in >= MOD) | (io.y_in >= MOD);

    always_comb begin
        sum_w = {1'b0, io.x_in} + {1'b0, io.y_in};
        dif_w = {1'b0, io.x_in} - {1'b0, io.y_in};
        s_nxt = io.op_sub ? dif_w[data_width-1:0] : sum_w[data_width-1:0];
        f_nxt = io.op_sub ? dif_w[data_width]     : sum_w[data_width];
    end

    // The flag is the carry for add and the borrow for sub. Both correct by exactly one M.
    always_comb begin
        r = s1;
        if (op1) begin
            if (f1) r = s1 + MOD;
        end else begin
            if (f1 || (s1 >= MOD)) r = s1 - MOD;
        end
        r_ext  = {1'b0, r};
        h_ext  = r[0] ? ((r_ext + MOD_W) >> 1) : (r_ext >> 1);
        result = h1 ? h_ext[data_width-1:0] : r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1           <= 1'b0;
            s1           <= '0;
            f1           <= 1'b0;
            op1          <= 1'b0;
            h1           <= 1'b0;
            io.out_valid <= 1'b0;
            io.z_out     <= '0;
            io.range_err <= 1'b0;
        end else begin
            if (accept && non_canon) io.range_err <= 1'b1;
            if (adv) begin
                v1 <= io.in_valid;
                if (io.in_valid) begin
                    s1  <= s_nxt;
                    f1  <= f_nxt;
                    op1 <= io.op_sub;
                    h1  <= io.half_en;
                end
                io.out_valid <= v1;
                if (v1) io.z_out <= result;
            end
        end
    end
endmodule

// File: tb/tb_modular_sub_half_pipe.sv
// Bench for modular_sub_half_pipe. A scoreboard of ((x +/- y) mod M) * 2^-half mod M checks every output beat.
// Directed vectors with literal answers exercise latency, wrap, borrow, halving, stall, reset and range flagging.
module tb_modular_sub_half_pipe;
    localparam int DW   = 14;
    localparam int M    = 12289;
    localparam int INV2 = (M + 1) / 2;

    typedef struct {
        int unsigned val;
        bit          care;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    modular_sub_half_pipe_if #(.data_width(DW)) bus ();

    modular_sub_half_pipe #(.data_width(DW), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;
    bit            re_model = 1'b0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_z = '0;
    int            rdy_mode = 0;

    function automatic int unsigned golden(int unsigned x, int unsigned y, bit op, bit half);
        int unsigned v;
        v = op ? (x + M - y) % M : (x + y) % M;
        if (half) v = (v * INV2) % M;
        return v;
    endfunction

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            re_model   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("range_err_track", bus.range_err, re_model);
            check("in_ready_rule", bus.in_ready, (!bus.out_valid) || bus.out_ready);
            if (stall_prev) begin
                check("stall_valid_hold", bus.out_valid, 1);
                check("stall_z_hold", bus.z_out, prev_z);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.care) check("model_z", bus.z_out, e.val);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_z     = bus.z_out;
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.care = (bus.x_in < M) && (bus.y_in < M);
                e.val  = e.care ? golden(bus.x_in, bus.y_in, bus.op_sub, bus.half_en) : 0;
                q.push_back(e);
                if (!e.care) re_model = 1'b1;
            end
        end
    end

    task automatic rand_ready();
        if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic drive_beat(input int unsigned x, input int unsigned y, input bit op, input bit half);
        int n = 0;
        bit got;
        bus.in_valid = 1'b1;
        bus.x_in     = DW'(x);
        bus.y_in     = DW'(y);
        bus.op_sub   = op;
        bus.half_en  = half;
        forever begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            rand_ready();
            if (got) break;
            n++;
            if (n > 1000) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rand_ready();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        idle(2);
    endtask

    task automatic directed(input string name, input int unsigned x, input int unsigned y,
                            input bit op, input bit half, input int unsigned expv);
        rdy_mode      = 0;
        bus.out_ready = 1'b1;
        drain();
        drive_beat(x, y, op, half);
        @(negedge clk);
        check({name, "_lat1_valid"}, bus.out_valid, 0);
        @(negedge clk);
        check({name, "_lat2_valid"}, bus.out_valid, 1);
        check({name, "_z"}, bus.z_out, expv);
        @(posedge clk);
        #1;
    endtask

    int unsigned dx[8]  = '{12288, 5000, 0,     5, 7000, 3,    5, 0};
    int unsigned dy[8]  = '{1,     6000, 1,     3, 7000, 4,    3, 12288};
    bit          dop[8] = '{0,     0,    1,     1, 1,    0,    1, 1};
    bit          dh[8]  = '{0,     0,    0,     0, 0,    1,    1, 1};
    int unsigned dz[8]  = '{0,     11000, 12288, 2, 0,    6148, 1, 6145};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.half_en   = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_z_out", bus.z_out, 0);
        check("reset_range_err", bus.range_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            directed($sformatf("dir%0d", i), dx[i], dy[i], dop[i], dh[i], dz[i]);

        // Stall mid-stream: output back-pressured for three cycles while beats keep arriving.
        drain();
        rdy_mode      = 2;
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_beat(1000 * i + 7, 1500 * i + 11, i[0], (i % 3) == 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("stall_in_ready_low", bus.in_ready, 0);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        rdy_mode = 0;
        drain();

        // Reset with two beats in flight.
        drive_beat(100, 200, 0, 0);
        drive_beat(300, 400, 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_range_err", bus.range_err, 0);
        idle(3);
        @(negedge clk);
        check("rst_mid_quiet", bus.out_valid, 0);
        @(posedge clk);
        #1;
        directed("post_rst", 5, 3, 1, 0, 2);

        // Sticky range flag.
        drive_beat(12289, 0, 0, 0);
        @(negedge clk);
        check("range_set", bus.range_err, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) drive_beat(i * 17, i * 29, i[0], i[1]);
        drain();
        @(negedge clk);
        check("range_sticky", bus.range_err, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("range_cleared", bus.range_err, 0);
        @(posedge clk);
        #1;

        // Random canonical traffic with random back-pressure and bubbles.
        rdy_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive_beat($urandom_range(0, M - 1), $urandom_range(0, M - 1),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rdy_mode      = 0;
        bus.out_ready = 1'b1;
        drain();
        check("final_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
